// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, widths and lock FSM state type for the
// VGA receive-side decoder.
//   H_ACTIVE/H_TOTAL/V_ACTIVE/V_TOTAL : 640x480@60 reference timing
//   LOCK_FRAMES                       : consecutive good frames needed to lock
//   CNT_W/COORD_W/RGB_W/ERR_W         : counter, coordinate, pixel, error widths
package vga_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int H_TOTAL     = 800;
    localparam int V_ACTIVE    = 480;
    localparam int V_TOTAL     = 525;
    localparam int LOCK_FRAMES = 2;

    localparam int CNT_W   = 11;
    localparam int COORD_W = 10;
    localparam int RGB_W   = 24;
    localparam int ERR_W   = 16;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers the raw VGA inputs once (stage 1) and produces
// single-cycle falling-edge pulses for the active-low HS and VS syncs.
//   clk, rst          : pixel clock, synchronous active-high reset
//   hs, vs            : raw sync pins (active low)
//   blank_n, rgb      : raw blank and pixel data
//   s1_blank_n, s1_rgb: stage-1 registered blank and pixel
//   hs_fall, vs_fall  : high for one cycle after a registered sync falls
module vga_sync_edge
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             hs,
    input  logic             vs,
    input  logic             blank_n,
    input  logic [RGB_W-1:0] rgb,
    output logic             s1_blank_n,
    output logic [RGB_W-1:0] s1_rgb,
    output logic             hs_fall,
    output logic             vs_fall
);

    logic s1_hs, s1_vs, prev_hs, prev_vs;

    // Syncs reset low so a pin that is already low at release is not
    // mistaken for a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            prev_hs    <= 1'b0;
            prev_vs    <= 1'b0;
            s1_blank_n <= 1'b0;
            s1_rgb     <= '0;
        end else begin
            s1_hs      <= hs;
            s1_vs      <= vs;
            prev_hs    <= s1_hs;
            prev_vs    <= s1_vs;
            s1_blank_n <= blank_n;
            s1_rgb     <= rgb;
        end
    end

    assign hs_fall = prev_hs & ~s1_hs;
    assign vs_fall = prev_vs & ~s1_vs;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from a VGA stream, measures
// line/frame totals and tracks lock against the expected timing.
//   i_clk_25M, i_rst             : pixel clock, synchronous active-high reset
//   i_hs, i_vs, i_blank_n, i_rgb : VGA inputs (syncs active low)
//   o_pixel, o_x, o_y, o_pix_valid : registered pixel and its coordinates
//   o_line_start, o_frame_start  : one-cycle pulses on HS / VS fall
//   o_h_total, o_v_total         : last measured line / frame totals
//   o_locked, o_err, o_err_cnt   : lock status, loss-of-lock pulse and count
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int LOCK_FRAMES = vga_pkg::LOCK_FRAMES
) (
    input  logic               i_clk_25M,
    input  logic               i_rst,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic               i_blank_n,
    input  logic [RGB_W-1:0]   i_rgb,
    output logic [RGB_W-1:0]   o_pixel,
    output logic               o_pix_valid,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [CNT_W-1:0]   o_h_total,
    output logic [CNT_W-1:0]   o_v_total,
    output logic               o_locked,
    output logic               o_err,
    output logic [ERR_W-1:0]   o_err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W:0]    H_TOTAL_C  = (CNT_W+1)'(H_TOTAL);
    localparam logic [CNT_W:0]    V_TOTAL_C  = (CNT_W+1)'(V_TOTAL);
    localparam logic [CNT_W-1:0]  H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  H_TIMEOUT  = CNT_W'(2 * H_TOTAL);
    localparam logic [GOOD_W-1:0] LOCK_LAST  = GOOD_W'(LOCK_FRAMES - 1);

    logic             s1_blank_n;
    logic [RGB_W-1:0] s1_rgb;
    logic             hs_fall, vs_fall;

    vga_sync_edge u_edge (
        .clk        (i_clk_25M),
        .rst        (i_rst),
        .hs         (i_hs),
        .vs         (i_vs),
        .blank_n    (i_blank_n),
        .rgb        (i_rgb),
        .s1_blank_n (s1_blank_n),
        .s1_rgb     (s1_rgb),
        .hs_fall    (hs_fall),
        .vs_fall    (vs_fall)
    );

    logic [CNT_W-1:0]  h_cnt, v_cnt, x_cnt, y_cnt;
    logic [CNT_W-1:0]  x_cur, y_cur;
    logic [CNT_W:0]    h_meas, v_meas;
    logic              line_active, line_bad;
    logic              h_ok, v_ok, frame_good, timeout;
    lock_state_t       state, state_nxt;
    logic [GOOD_W-1:0] good_cnt, good_cnt_nxt;
    logic              err_nxt;

    // Measurements are one wider so a saturated counter still reads as wrong.
    assign h_meas     = {1'b0, h_cnt} + 1'b1;
    assign v_meas     = {1'b0, v_cnt} + 1'b1;
    assign h_ok       = (h_meas == H_TOTAL_C);
    assign v_ok       = (v_meas == V_TOTAL_C);
    assign timeout    = (h_cnt >= H_TIMEOUT);
    assign frame_good = v_ok & ~line_bad & ~(hs_fall & ~h_ok);

    // Coordinates of the stage-1 pixel, with this cycle's edges applied.
    assign x_cur = hs_fall ? '0 : x_cnt;
    assign y_cur = vs_fall ? '0 : ((hs_fall & line_active) ? sat_inc(y_cnt) : y_cnt);

    assign o_locked = (state == LOCKED);

    // Stage 2: measurement counters and registered outputs
    always_ff @(posedge i_clk_25M) begin
        if (i_rst) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            line_active   <= 1'b0;
            line_bad      <= 1'b0;
            o_pixel       <= '0;
            o_pix_valid   <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_h_total     <= '0;
            o_v_total     <= '0;
        end else begin
            h_cnt <= hs_fall ? '0 : sat_inc(h_cnt);
            if (hs_fall)
                o_h_total <= h_meas[CNT_W] ? '1 : h_meas[CNT_W-1:0];

            // The HS fall that coincides with VS belongs to the new frame.
            if (vs_fall) begin
                v_cnt     <= '0;
                o_v_total <= v_meas[CNT_W] ? '1 : v_meas[CNT_W-1:0];
            end else if (hs_fall) begin
                v_cnt <= sat_inc(v_cnt);
            end

            line_bad    <= vs_fall ? 1'b0 : (line_bad | (hs_fall & ~h_ok));
            line_active <= s1_blank_n | (line_active & ~hs_fall);
            x_cnt       <= s1_blank_n ? sat_inc(x_cur) : x_cur;
            y_cnt       <= y_cur;

            o_pixel       <= s1_rgb;
            o_x           <= x_cur[COORD_W-1:0];
            o_y           <= y_cur[COORD_W-1:0];
            o_pix_valid   <= s1_blank_n & o_locked & (x_cur < H_ACT_C) & (y_cur < V_ACT_C);
            o_line_start  <= hs_fall;
            o_frame_start <= vs_fall;
        end
    end

    always_ff @(posedge i_clk_25M) begin
        if (i_rst) begin
            state     <= SEARCH;
            good_cnt  <= '0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
            o_err    <= err_nxt;
            if (err_nxt && !(&o_err_cnt))
                o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        err_nxt      = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nxt    = CHECK;
                    good_cnt_nxt = '0;
                end
            end
            CHECK: begin
                if (timeout) begin
                    state_nxt = SEARCH;
                end else if (vs_fall) begin
                    if (frame_good) begin
                        good_cnt_nxt = good_cnt + 1'b1;
                        if (good_cnt == LOCK_LAST)
                            state_nxt = LOCKED;
                    end else begin
                        good_cnt_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if ((hs_fall & ~h_ok) | (vs_fall & ~v_ok) | timeout) begin
                    state_nxt = SEARCH;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder using a reduced 16x8 timing (8x4 active)
// so complete frames stay short. Stimulus pushes expected pixels into a
// queue; a monitor pops and compares whenever o_pix_valid is seen.
module tb_vga_sync_decoder;

    localparam int H_ACT = 8;
    localparam int H_TOT = 16;
    localparam int V_ACT = 4;
    localparam int V_TOT = 8;
    localparam int HS_W  = 2;
    localparam int H_ST  = 4;   // first active column
    localparam int VS_W  = 2;
    localparam int V_ST  = 2;   // first active line

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs = 1'b1, vs = 1'b1, blank_n = 1'b0;
    logic [23:0] rgb = '0;

    logic [23:0] o_pixel;
    logic        o_pix_valid, o_line_start, o_frame_start, o_locked, o_err;
    logic [9:0]  o_x, o_y;
    logic [10:0] o_h_total, o_v_total;
    logic [15:0] o_err_cnt;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int fs_seen = 0;
    int frames_driven = 0;
    logic [43:0] exp_q[$];

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .V_ACTIVE(V_ACT),
        .V_TOTAL(V_TOT), .LOCK_FRAMES(2)
    ) dut (
        .i_clk_25M     (clk),
        .i_rst         (rst),
        .i_hs          (hs),
        .i_vs          (vs),
        .i_blank_n     (blank_n),
        .i_rgb         (rgb),
        .o_pixel       (o_pixel),
        .o_pix_valid   (o_pix_valid),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_line_start  (o_line_start),
        .o_frame_start (o_frame_start),
        .o_h_total     (o_h_total),
        .o_v_total     (o_v_total),
        .o_locked      (o_locked),
        .o_err         (o_err),
        .o_err_cnt     (o_err_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected pixel per valid output.
    always @(negedge clk) begin
        if (o_pix_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d pixel=%0h expected none",
                         o_x, o_y, o_pixel);
            end else begin
                logic [43:0] e;
                e = exp_q.pop_front();
                if ({o_x, o_y, o_pixel} !== e) begin
                    bad++;
                    $display("FAIL pix: got x=%0d y=%0d pixel=%0h expected x=%0d y=%0d pixel=%0h",
                             o_x, o_y, o_pixel, e[43:34], e[33:24], e[23:0]);
                end
            end
        end
        if (o_err) begin
            err_seen++;
            chk("err_with_unlock", {63'd0, o_locked}, 64'd0);
        end
        if (o_frame_start) fs_seen++;
    end

    task automatic cyc(input logic h, input logic v, input logic b, input logic [23:0] d);
        @(negedge clk);
        hs = h; vs = v; blank_n = b; rgb = d;
    endtask

    // One line of `cols` clocks; active pixels pushed when y < valid_rows.
    task automatic drive_line(input int ln, input int cols, input int valid_rows);
        for (int c = 0; c < cols; c++) begin
            logic act;
            int x, y;
            logic [23:0] d;
            x = c - H_ST;
            y = ln - V_ST;
            act = (ln >= V_ST) && (ln < V_ST + V_ACT) && (c >= H_ST) && (c < H_ST + H_ACT);
            d = act ? {8'(x), 8'(y), 8'hA5} : 24'h0;
            if (act && (y < valid_rows))
                exp_q.push_back({10'(x), 10'(y), d});
            cyc(!(c < HS_W), !(ln < VS_W), act, d);
        end
    endtask

    task automatic drive_frame(input int bad_line, input int valid_rows);
        frames_driven++;
        for (int ln = 0; ln < V_TOT; ln++)
            drive_line(ln, (ln == bad_line) ? H_TOT + 1 : H_TOT, valid_rows);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_locked", {63'd0, o_locked}, 64'd0);
        chk("reset_err_cnt", {48'd0, o_err_cnt}, 64'd0);
        chk("reset_totals", {42'd0, o_h_total, o_v_total}, 64'd0);
        rst = 1'b0;
        idle(2);

        // Clean frames: lock at the 3rd VS fall.
        drive_frame(-1, 0);
        drive_frame(-1, 0);
        chk("lock_after_2_vs", {63'd0, o_locked}, 64'd0);
        drive_frame(-1, V_ACT);
        chk("lock_after_3_vs", {63'd0, o_locked}, 64'd1);
        drive_frame(-1, V_ACT);
        chk("h_total", {53'd0, o_h_total}, 64'(H_TOT));
        chk("v_total", {53'd0, o_v_total}, 64'(V_TOT));
        chk("pix_queue_drained", 64'(exp_q.size()), 64'd0);

        // One long line while locked.
        drive_frame(3, 2);
        chk("badline_err_cnt", {48'd0, o_err_cnt}, 64'd1);
        chk("badline_locked", {63'd0, o_locked}, 64'd0);
        chk("badline_err_pulses", 64'(err_seen), 64'd1);
        drive_frame(-1, 0);
        drive_frame(-1, 0);
        chk("relock_pending", {63'd0, o_locked}, 64'd0);
        drive_frame(-1, V_ACT);
        chk("relock", {63'd0, o_locked}, 64'd1);

        // HS stuck high past the timeout.
        idle(2 * H_TOT + 8);
        chk("timeout_locked", {63'd0, o_locked}, 64'd0);
        chk("timeout_err_cnt", {48'd0, o_err_cnt}, 64'd2);
        chk("timeout_h_total_held", {53'd0, o_h_total}, 64'(H_TOT));

        // Relock, then reset mid-line.
        drive_frame(-1, 0);
        drive_frame(-1, 0);
        drive_frame(-1, V_ACT);
        chk("relock2", {63'd0, o_locked}, 64'd1);
        frames_driven++;
        drive_line(0, H_TOT, V_ACT);
        drive_line(1, H_TOT, V_ACT);
        drive_line(2, H_TOT, V_ACT);
        drive_line(3, 3, V_ACT);
        @(negedge clk);
        rst = 1'b1; hs = 1'b1; vs = 1'b1; blank_n = 1'b0; rgb = '0;
        @(negedge clk);
        chk("midreset_locked", {63'd0, o_locked}, 64'd0);
        chk("midreset_outputs",
            {o_pixel, o_x, o_y, o_pix_valid, o_line_start, o_frame_start, o_err, 16'd0}, 64'd0);
        chk("midreset_status", {o_h_total, o_v_total, o_err_cnt, 26'd0}, 64'd0);
        rst = 1'b0;
        idle(2);
        drive_frame(-1, 0);
        drive_frame(-1, 0);
        chk("postreset_pending", {63'd0, o_locked}, 64'd0);
        drive_frame(-1, V_ACT);
        chk("postreset_lock", {63'd0, o_locked}, 64'd1);

        // Error counter saturation.
        fork
            drive_frame(3, 2);
            begin
                repeat (8) @(negedge clk);
                force dut.o_err_cnt = 16'hFFFF;
                @(negedge clk);
                release dut.o_err_cnt;
                @(negedge clk);
                chk("sat_preset", {48'd0, o_err_cnt}, 64'hFFFF);
            end
        join
        chk("sat_err_cnt", {48'd0, o_err_cnt}, 64'hFFFF);
        chk("sat_locked", {63'd0, o_locked}, 64'd0);

        idle(6);
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        chk("final_err_pulses", 64'(err_seen), 64'd3);
        chk("final_frame_starts", 64'(fs_seen), 64'(frames_driven));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart to the board's VGA timing generator. It samples HS, VS, BLANK_N and 24-bit RGB in the 25 MHz pixel domain, recovers pixel coordinates, measures line and frame totals, and runs a lock state machine against the expected 640x480@60 timing. It sits on a loopback or capture path next to the VGA output and provides self-check and status for LEDs and HEX displays.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to lock
- i_clk_25M  in  1  pixel clock; the only clock
- i_rst  in  1  synchronous, active-high reset
- i_hs, i_vs  in  1  sync inputs, active low
- i_blank_n  in  1  high during active video
- i_rgb  in  24  {R,G,B}
- o_pixel  out  24  registered pixel
- o_pix_valid  out  1  high when o_pixel/o_x/o_y are a valid active pixel
- o_x, o_y  out  10  active pixel coordinates
- o_line_start, o_frame_start  out  1  one-cycle pulses
- o_h_total, o_v_total  out  11  last measured line and frame totals
- o_locked  out  1  lock status
- o_err  out  1  one-cycle pulse on loss of lock
- o_err_cnt  out  16  count of lock losses, saturating

## Operation
- Stage 1 registers all inputs (s1_*). hs_fall = prev_hs & ~s1_hs; vs_fall is defined the same way.
- h_cnt (11b) counts clocks since the last hs_fall and saturates at 2047.
  - On hs_fall: o_h_total <= h_cnt+1, h_cnt <= 0.
- v_cnt (11b) counts hs_falls after frame start.
  - On vs_fall: o_v_total <= v_cnt+1, v_cnt <= 0.
  - An hs_fall coincident with vs_fall belongs to the new frame and does not increment v_cnt.
- x_cnt is cleared on hs_fall and incremented on each s1_blank_n cycle.
- A line_active flag is set by s1_blank_n and cleared on hs_fall.
- y_cnt is incremented on hs_fall if line_active, and cleared on vs_fall (vs_fall takes priority).
- o_pix_valid = s1_blank_n & o_locked & x_cnt<H_ACTIVE & y_cnt<V_ACTIVE. o_x, o_y and o_pixel are updated every cycle.
- A line_bad sticky flag is set when an hs_fall measures h_cnt+1 != H_TOTAL. It is cleared on vs_fall.
- FSM states SEARCH, CHECK, LOCKED:
  - SEARCH: the first vs_fall moves to CHECK with good_cnt=0.
  - CHECK: on vs_fall, a good frame is v_cnt+1==V_TOTAL & !line_bad (including the current hs check).
    - A good frame increments good_cnt; reaching LOCK_FRAMES moves to LOCKED.
    - A bad frame sets good_cnt=0 and stays in CHECK.
  - LOCKED: any hs_fall with a wrong h total, a vs_fall with a wrong v total, or h_cnt reaching 2*H_TOTAL (timeout) does the following:
    - goes to SEARCH;
    - pulses o_err;
    - increments o_err_cnt.
  - The timeout applies in CHECK as well, returning to SEARCH without pulsing o_err.
- Reset clears all outputs, counters and flags to 0 and sets state to SEARCH.
- Reset mid-frame discards any partial measurement.

## Timing
- Input-to-output latency is 2 clocks for o_pixel, o_x, o_y and o_pix_valid.
- o_line_start and o_frame_start pulse in the cycle after the edge is detected, which is 2 clocks after the pin edge.
- o_h_total and o_v_total update in that same cycle.
- o_locked changes in the cycle after the deciding edge is registered. o_err is coincident with o_locked falling.
- Back-to-back edges are handled every cycle with no dead time.

## Structure
- A shared vga_pkg holds:
  - the 640x480 timing constants (H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL, widths);
  - the lock_state_t enum {SEARCH, CHECK, LOCKED}.
- One sub-module, vga_sync_edge, handles input registering, previous-value registers and fall-pulse generation for HS and VS.

## Test plan
- Reset asserted mid-line after lock -> next cycle all outputs are 0 and o_locked=0. After release, lock is reacquired at the 3rd vs_fall.
- Clean 800x525 timing with HS/VS negative and VS aligned to an HS fall:
  - o_locked rises after the 3rd vs_fall (SEARCH->CHECK, then 2 good frames);
  - o_h_total=800, o_v_total=525 (not 526).
- i_rgb={x[7:0],y[7:0],8'hA5} -> every valid o_pixel matches o_x/o_y. There are exactly 307200 o_pix_valid cycles per locked frame, and o_x wraps 639->0.
- One 801-clock line while locked:
  - o_err pulses once, o_err_cnt=1, o_locked=0;
  - relock occurs 2 good frames after the next vs_fall.
- HS held high for 1600 clocks while locked -> o_err pulse and state SEARCH. o_h_total holds its last value.
- o_err_cnt forced to 16'hFFFF, then one lock loss -> it stays at 16'hFFFF.
